// File: rtl/fp_division.sv
// rtl/fp_division.sv - sequential restoring radix-2 divider for unsigned 3Qp operands
// One quotient bit per clock; start/ready/valid handshake with saturation on overflow and divide-by-zero.
module fp_division #(
   parameter int unsigned p = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3+p-1:0]   f1,
   input  logic [3+p-1:0]   f2,
   output logic             ready,
   output logic             valid,
   output logic [3+p-1:0]   q,
   output logic             ovf,
   output logic             dz
);

   localparam int unsigned W  = 3 + p;
   localparam int unsigned NW = W + p;
   localparam int unsigned CW = $clog2(NW + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   // The dividend shift register doubles as the quotient register: each CALC
   // cycle its MSB moves into the remainder and the new quotient bit enters at the LSB.
   logic [NW-1:0] n_sr;
   logic [W:0]    rem;
   logic [W-1:0]  f2_r;
   logic [CW-1:0] cnt;

   logic [W+1:0]  rem_sh;
   logic [W:0]    diff;
   logic          q_bit;
   logic [W:0]    rem_nxt;
   logic [NW-1:0] n_nxt;
   logic          accept;
   logic          last_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      valid     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = (f2 == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == CNT_LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            valid     = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The remainder stays below f2, so once the trial subtraction succeeds the
   // difference always fits in W+1 bits.
   always_comb begin
      rem_sh    = {rem, n_sr[NW-1]};
      q_bit     = (rem_sh >= {2'b00, f2_r});
      diff      = rem_sh[W:0] - {1'b0, f2_r};
      rem_nxt   = q_bit ? diff : rem_sh[W:0];
      n_nxt     = {n_sr[NW-2:0], q_bit};
      accept    = (state == IDLE) && start;
      last_step = (state == CALC) && (cnt == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_sr <= '0;
         rem  <= '0;
         f2_r <= '0;
         cnt  <= '0;
         q    <= '0;
         ovf  <= 1'b0;
         dz   <= 1'b0;
      end else if (accept) begin
         n_sr <= {f1, {p{1'b0}}};
         rem  <= '0;
         f2_r <= f2;
         cnt  <= '0;
         if (f2 == '0) begin
            q   <= '1;
            ovf <= 1'b0;
            dz  <= 1'b1;
         end
      end else if (state == CALC) begin
         n_sr <= n_nxt;
         rem  <= rem_nxt;
         cnt  <= cnt + 1'b1;
         if (last_step) begin
            dz <= 1'b0;
            if (|n_nxt[NW-1:W]) begin
               q   <= '1;
               ovf <= 1'b1;
            end else begin
               q   <= n_nxt[W-1:0];
               ovf <= 1'b0;
            end
         end
      end
   end

endmodule
